// File: rtl/hnm_access_scheduler.sv
// Hit-map BRAM access scheduler: arbitrates SSID marks and queries, performs the
// read-modify-write for marks and owns the full-memory clear sweep.
//
// state  | meaning
// CLEAR  | writing zero to one row per cycle, rows ascending
// DRAIN  | letting the last sweep writes settle before serving requests
// IDLE   | ready to accept one mark or one query
// ISSUE  | port-B read of the latched row is on the bus
// WAIT   | remaining BRAM read latency
// UPDATE | read data valid: report the hit or write back the set bit
module hnm_access_scheduler #(
   parameter int ROW_BITS = 7,
   parameter int COL_BITS = 5,
   parameter int BRAM_LAT = 2,
   localparam int SSID_BITS = ROW_BITS + COL_BITS,
   localparam int ROW_W = 2 ** COL_BITS
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 clear_req,
   input  logic                 wr_valid,
   input  logic [SSID_BITS-1:0] wr_ssid,
   output logic                 wr_ready,
   input  logic                 rd_valid,
   input  logic [SSID_BITS-1:0] rd_ssid,
   output logic                 rd_ready,
   output logic                 hit_valid,
   output logic                 hit,
   output logic                 busy,
   output logic                 bram_we,
   output logic [ROW_BITS-1:0]  bram_waddr,
   output logic [ROW_W-1:0]     bram_wdata,
   output logic                 bram_re,
   output logic [ROW_BITS-1:0]  bram_raddr,
   input  logic [ROW_W-1:0]     bram_rdata
);

   localparam int CNT_W = $clog2(BRAM_LAT + 2);
   localparam int DRAIN_INIT = BRAM_LAT + 1;
   localparam int WAIT_INIT = (BRAM_LAT > 1) ? BRAM_LAT - 2 : 0;

   typedef enum logic [2:0] {CLEAR, DRAIN, IDLE, ISSUE, WAIT, UPDATE} state_t;

   state_t              state;
   logic [ROW_BITS-1:0] rowCnt;
   logic [ROW_BITS-1:0] rowQ;
   logic [COL_BITS-1:0] colQ;
   logic                isMarkQ;
   logic                lastWasWr;
   logic [CNT_W-1:0]    cnt;
   logic                bitSet;

   // Contested requests go to the side that was not granted last time.
   always_comb begin
      wr_ready = 1'b0;
      rd_ready = 1'b0;
      if (state == IDLE && !clear_req) begin
         wr_ready = wr_valid && (!rd_valid || !lastWasWr);
         rd_ready = rd_valid && (!wr_valid || lastWasWr);
      end
   end

   assign bitSet = bram_rdata[colQ];

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= CLEAR;
         rowCnt     <= '0;
         rowQ       <= '0;
         colQ       <= '0;
         isMarkQ    <= 1'b0;
         lastWasWr  <= 1'b0;
         cnt        <= '0;
         busy       <= 1'b1;
         hit_valid  <= 1'b0;
         hit        <= 1'b0;
         bram_we    <= 1'b0;
         bram_waddr <= '0;
         bram_wdata <= '0;
         bram_re    <= 1'b0;
         bram_raddr <= '0;
      end else begin
         bram_we   <= 1'b0;
         bram_re   <= 1'b0;
         hit_valid <= 1'b0;
         unique case (state)
            CLEAR: begin
               bram_we    <= 1'b1;
               bram_waddr <= rowCnt;
               bram_wdata <= '0;
               if (rowCnt == '1) begin
                  rowCnt <= '0;
                  cnt    <= CNT_W'(DRAIN_INIT);
                  state  <= DRAIN;
               end else begin
                  rowCnt <= rowCnt + 1'b1;
               end
            end
            DRAIN: begin
               if (cnt == '0) begin
                  busy  <= 1'b0;
                  state <= IDLE;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            IDLE: begin
               if (clear_req) begin
                  busy   <= 1'b1;
                  rowCnt <= '0;
                  state  <= CLEAR;
               end else if (wr_valid && wr_ready) begin
                  isMarkQ    <= 1'b1;
                  lastWasWr  <= 1'b1;
                  rowQ       <= wr_ssid[SSID_BITS-1:COL_BITS];
                  colQ       <= wr_ssid[COL_BITS-1:0];
                  bram_re    <= 1'b1;
                  bram_raddr <= wr_ssid[SSID_BITS-1:COL_BITS];
                  state      <= ISSUE;
               end else if (rd_valid && rd_ready) begin
                  isMarkQ    <= 1'b0;
                  lastWasWr  <= 1'b0;
                  rowQ       <= rd_ssid[SSID_BITS-1:COL_BITS];
                  colQ       <= rd_ssid[COL_BITS-1:0];
                  bram_re    <= 1'b1;
                  bram_raddr <= rd_ssid[SSID_BITS-1:COL_BITS];
                  state      <= ISSUE;
               end
            end
            ISSUE: begin
               cnt   <= CNT_W'(WAIT_INIT);
               state <= (BRAM_LAT > 1) ? WAIT : UPDATE;
            end
            WAIT: begin
               if (cnt == '0) begin
                  state <= UPDATE;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            UPDATE: begin
               // An already-set bit needs no write-back.
               if (isMarkQ) begin
                  if (!bitSet) begin
                     bram_we    <= 1'b1;
                     bram_waddr <= rowQ;
                     bram_wdata <= bram_rdata | (ROW_W'(1) << colQ);
                  end
               end else begin
                  hit_valid <= 1'b1;
                  hit       <= bitSet;
               end
               state <= IDLE;
            end
            default: state <= CLEAR;
         endcase
      end
   end

endmodule

// File: tb/tb_hnm_access_scheduler.sv
// Bench for hnm_access_scheduler: BRAM model, bitmap reference model checked every
// cycle, a vector table for the basic ops and sequences for arbitration/reset/clear.
module tb_hnm_access_scheduler;

   localparam int ROW_BITS = 7;
   localparam int COL_BITS = 5;
   localparam int BRAM_LAT = 2;
   localparam int ROWS = 128;
   localparam int OP_CYC = BRAM_LAT + 2;
   localparam int SWEEP = ROWS + BRAM_LAT + 2;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        clear_req = 1'b0;
   logic        wr_valid = 1'b0;
   logic        rd_valid = 1'b0;
   logic [11:0] wr_ssid = '0;
   logic [11:0] rd_ssid = '0;
   logic        wr_ready, rd_ready, hit_valid, hit, busy, bram_we, bram_re;
   logic [6:0]  bram_waddr, bram_raddr;
   logic [31:0] bram_wdata, bram_rdata;

   hnm_access_scheduler #(.ROW_BITS(ROW_BITS), .COL_BITS(COL_BITS), .BRAM_LAT(BRAM_LAT)) dut (
      .clk(clk), .reset(reset), .clear_req(clear_req),
      .wr_valid(wr_valid), .wr_ssid(wr_ssid), .wr_ready(wr_ready),
      .rd_valid(rd_valid), .rd_ssid(rd_ssid), .rd_ready(rd_ready),
      .hit_valid(hit_valid), .hit(hit), .busy(busy),
      .bram_we(bram_we), .bram_waddr(bram_waddr), .bram_wdata(bram_wdata),
      .bram_re(bram_re), .bram_raddr(bram_raddr), .bram_rdata(bram_rdata)
   );

   always #5 clk = ~clk;

   // Simple dual-port BRAM; contents are scrambled while reset is held.
   logic [31:0] mem [ROWS];
   logic [31:0] pipe [BRAM_LAT];
   always @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < ROWS; i++) mem[i] <= $urandom();
      end else if (bram_we) begin
         mem[bram_waddr] <= bram_wdata;
      end
      pipe[0] <= bram_re ? mem[bram_raddr] : 32'hDEAD_BEEF;
      for (int i = 1; i < BRAM_LAT; i++) pipe[i] <= pipe[i-1];
   end
   assign bram_rdata = pipe[BRAM_LAT-1];

   typedef struct {
      int          cyc;
      logic [6:0]  addr;
      logic [31:0] data;
   } ev_t;

   typedef struct {
      bit          isMark;
      logic [11:0] ssid;
      bit          expHit;
      int          expWe;
   } vec_t;

   int          nCmp = 0;
   int          nBad = 0;
   int          cyc = 0;
   int          freeAt = 0;
   int          clearStart = 0;
   bit          mLastWr = 1'b0;
   logic [31:0] refRow [ROWS];
   ev_t         hq[$];
   ev_t         wq[$];
   ev_t         rq[$];
   logic        accWr, accRd, hvSeen, hitSeen, weSeen;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      nCmp++;
      if (got !== exp) begin
         nBad++;
         $display("FAIL %s cyc=%0d got=0x%0h exp=0x%0h", name, cyc, got, exp);
      end
   endtask

   task automatic failNote(input string name);
      nCmp++;
      nBad++;
      $display("FAIL %s cyc=%0d bound expired", name, cyc);
   endtask

   task automatic zeroRef();
      for (int i = 0; i < ROWS; i++) refRow[i] = '0;
   endtask

   // One clock cycle: compare DUT against the reference, then advance the reference.
   task automatic tick();
      logic        idle, expWr, expRd, expHv, expWe, expRe;
      logic [31:0] expH, expAddr, expData, expRaddr;
      logic [6:0]  row;
      logic [4:0]  col;
      ev_t         e;
      #2;
      idle  = (cyc >= freeAt);
      expWr = idle && !clear_req && wr_valid && (!rd_valid || !mLastWr);
      expRd = idle && !clear_req && rd_valid && (!wr_valid || mLastWr);
      check("wr_ready", 32'(wr_ready), 32'(expWr));
      check("rd_ready", 32'(rd_ready), 32'(expRd));
      check("busy", 32'(busy), 32'(cyc >= clearStart && cyc < clearStart + SWEEP));

      expHv = 1'b0; expH = '0;
      if (hq.size() > 0 && hq[0].cyc == cyc) begin
         e = hq.pop_front(); expHv = 1'b1; expH = e.data;
      end
      check("hit_valid", 32'(hit_valid), 32'(expHv));
      if (expHv) check("hit", 32'(hit), expH);

      expWe = 1'b0; expAddr = '0; expData = '0;
      if (cyc > clearStart && cyc <= clearStart + ROWS) begin
         expWe = 1'b1; expAddr = 32'(cyc - clearStart - 1);
      end else if (wq.size() > 0 && wq[0].cyc == cyc) begin
         e = wq.pop_front(); expWe = 1'b1; expAddr = 32'(e.addr); expData = e.data;
      end
      check("bram_we", 32'(bram_we), 32'(expWe));
      if (expWe) begin
         check("bram_waddr", 32'(bram_waddr), expAddr);
         check("bram_wdata", bram_wdata, expData);
      end

      expRe = 1'b0; expRaddr = '0;
      if (rq.size() > 0 && rq[0].cyc == cyc) begin
         e = rq.pop_front(); expRe = 1'b1; expRaddr = 32'(e.addr);
      end
      check("bram_re", 32'(bram_re), 32'(expRe));
      if (expRe) check("bram_raddr", 32'(bram_raddr), expRaddr);

      if (reset) begin
         while (hq.size() > 0 && hq[hq.size()-1].cyc > cyc) e = hq.pop_back();
         while (wq.size() > 0 && wq[wq.size()-1].cyc > cyc) e = wq.pop_back();
         while (rq.size() > 0 && rq[rq.size()-1].cyc > cyc) e = rq.pop_back();
         clearStart = cyc + 1; freeAt = cyc + 1 + SWEEP; mLastWr = 1'b0; zeroRef();
      end else if (idle && clear_req) begin
         clearStart = cyc + 1; freeAt = cyc + 1 + SWEEP; zeroRef();
      end else if (expWr) begin
         row = wr_ssid[11:5]; col = wr_ssid[4:0];
         rq.push_back('{cyc + 1, row, 32'd0});
         if (!refRow[row][col]) begin
            refRow[row][col] = 1'b1;
            wq.push_back('{cyc + OP_CYC, row, refRow[row]});
         end
         mLastWr = 1'b1; freeAt = cyc + OP_CYC;
      end else if (expRd) begin
         row = rd_ssid[11:5]; col = rd_ssid[4:0];
         rq.push_back('{cyc + 1, row, 32'd0});
         hq.push_back('{cyc + OP_CYC, row, 32'(refRow[row][col])});
         mLastWr = 1'b0; freeAt = cyc + OP_CYC;
      end

      accWr = wr_valid && wr_ready;
      accRd = rd_valid && rd_ready;
      hvSeen = hit_valid; hitSeen = hit; weSeen = bram_we;
      @(posedge clk); #1;
      cyc++;
   endtask

   task automatic waitIdle();
      for (int i = 0; i < SWEEP + 20 && cyc < freeAt; i++) tick();
   endtask

   task automatic doOp(input bit isMark, input logic [11:0] ssid,
                       output logic gotHit, output int hvCount, output int weCount, output int accCyc);
      gotHit = 1'b0; hvCount = 0; weCount = 0; accCyc = -1;
      if (isMark) begin wr_valid = 1'b1; wr_ssid = ssid; end
      else begin rd_valid = 1'b1; rd_ssid = ssid; end
      for (int i = 0; i < 400 && accCyc < 0; i++) begin
         tick();
         if (accWr || accRd) accCyc = cyc - 1;
      end
      wr_valid = 1'b0; rd_valid = 1'b0;
      if (accCyc < 0) failNote("accept_timeout");
      for (int k = 0; k < OP_CYC; k++) begin
         tick();
         if (hvSeen) begin hvCount++; gotHit = hitSeen; end
         if (weSeen) weCount++;
      end
   endtask

   vec_t vecs[12];

   initial begin
      logic gotHit;
      int   hvCount, weCount, accCyc;
      int   gCyc[$];
      bit   gWr[$];

      vecs[0]  = '{1'b0, 12'h0A5, 1'b0, 0};
      vecs[1]  = '{1'b1, 12'h0A5, 1'b0, 1};
      vecs[2]  = '{1'b0, 12'h0A5, 1'b1, 0};
      vecs[3]  = '{1'b0, 12'h0A4, 1'b0, 0};
      vecs[4]  = '{1'b1, 12'h0A5, 1'b0, 0};
      vecs[5]  = '{1'b0, 12'h0A5, 1'b1, 0};
      vecs[6]  = '{1'b1, 12'hFFF, 1'b0, 1};
      vecs[7]  = '{1'b0, 12'hFFF, 1'b1, 0};
      vecs[8]  = '{1'b0, 12'hFE0, 1'b0, 0};
      vecs[9]  = '{1'b1, 12'h000, 1'b0, 1};
      vecs[10] = '{1'b0, 12'h000, 1'b1, 0};
      vecs[11] = '{1'b0, 12'h01F, 1'b0, 0};

      zeroRef();
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
      cyc = 0; clearStart = 0; freeAt = SWEEP; mLastWr = 1'b0;

      // Basic ops; the first query waits out the power-on sweep.
      for (int i = 0; i < 12; i++) begin
         doOp(vecs[i].isMark, vecs[i].ssid, gotHit, hvCount, weCount, accCyc);
         if (i == 0) check("first_accept_cycle", 32'(accCyc), 32'd132);
         check("vec_hit_count", 32'(hvCount), vecs[i].isMark ? 32'd0 : 32'd1);
         check("vec_we_count", 32'(weCount), 32'(vecs[i].expWe));
         if (!vecs[i].isMark) check("vec_hit", 32'(gotHit), 32'(vecs[i].expHit));
      end

      // Both streams held valid: grants alternate W,R,W,R every OP_CYC cycles.
      wr_valid = 1'b1; rd_valid = 1'b1;
      wr_ssid = 12'($urandom_range(0, 4095)); rd_ssid = 12'($urandom_range(0, 4095));
      for (int i = 0; i < 40 && gCyc.size() < 6; i++) begin
         tick();
         if (accWr || accRd) begin
            check("single_grant", 32'(accWr && accRd), 32'd0);
            gCyc.push_back(cyc - 1); gWr.push_back(accWr);
            wr_ssid = 12'($urandom_range(0, 4095)); rd_ssid = 12'($urandom_range(0, 4095));
         end
      end
      wr_valid = 1'b0; rd_valid = 1'b0;
      for (int k = 0; k < OP_CYC; k++) tick();
      check("rr_grant_count", 32'(gCyc.size()), 32'd6);
      if (gWr.size() > 0) check("rr_first_is_write", 32'(gWr[0]), 32'd1);
      for (int k = 1; k < gCyc.size(); k++) begin
         check("rr_alternate", 32'(gWr[k]), 32'(!gWr[k-1]));
         check("rr_spacing", 32'(gCyc[k] - gCyc[k-1]), 32'(OP_CYC));
      end

      // Reset during WAIT of a query of a set bit: no result, sweep restarts at row 0.
      doOp(1'b1, 12'h0A5, gotHit, hvCount, weCount, accCyc);
      rd_valid = 1'b1; rd_ssid = 12'h0A5; accCyc = -1;
      for (int i = 0; i < 20 && accCyc < 0; i++) begin
         tick();
         if (accRd) accCyc = cyc - 1;
      end
      rd_valid = 1'b0;
      if (accCyc < 0) failNote("reset_query_accept");
      tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      hvCount = 0;
      for (int k = 0; k < 10; k++) begin
         tick();
         if (hvSeen) hvCount++;
      end
      check("aborted_hit_count", 32'(hvCount), 32'd0);
      waitIdle();
      doOp(1'b0, 12'h0A5, gotHit, hvCount, weCount, accCyc);
      check("after_reset_hit", 32'(gotHit), 32'd0);

      // Marks survive until an explicit clear request wipes them.
      doOp(1'b1, 12'h123, gotHit, hvCount, weCount, accCyc);
      doOp(1'b1, 12'h456, gotHit, hvCount, weCount, accCyc);
      doOp(1'b0, 12'h123, gotHit, hvCount, weCount, accCyc);
      check("pre_clear_hit", 32'(gotHit), 32'd1);
      clear_req = 1'b1;
      tick();
      clear_req = 1'b0;
      waitIdle();
      doOp(1'b0, 12'h123, gotHit, hvCount, weCount, accCyc);
      check("post_clear_hit_a", 32'(gotHit), 32'd0);
      doOp(1'b0, 12'h456, gotHit, hvCount, weCount, accCyc);
      check("post_clear_hit_b", 32'(gotHit), 32'd0);

      // Random traffic on a few rows so marks and queries collide.
      for (int i = 0; i < 1500; i++) begin
         wr_valid  = ($urandom_range(0, 99) < 45);
         rd_valid  = ($urandom_range(0, 99) < 45);
         wr_ssid   = {7'($urandom_range(60, 63)), 5'($urandom_range(0, 31))};
         rd_ssid   = {7'($urandom_range(60, 63)), 5'($urandom_range(0, 31))};
         clear_req = ($urandom_range(0, 399) == 0);
         tick();
      end
      wr_valid = 1'b0; rd_valid = 1'b0; clear_req = 1'b0;
      waitIdle();
      for (int k = 0; k < OP_CYC + 1; k++) tick();
      check("hit_queue_drained", 32'(hq.size()), 32'd0);
      check("write_queue_drained", 32'(wq.size()), 32'd0);
      check("read_queue_drained", 32'(rq.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog cyc=%0d simulation did not finish", cyc);
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/hnm_access_scheduler.md
Name: hnm_access_scheduler

Overview:
Sequences all accesses to the hit-map (HNM) BRAM.
- Arbitrates between an SSID mark stream (set bit) and an SSID query stream (test bit).
- Performs read-modify-write for marks.
- Runs the full-memory clear sweep after reset or on request.
- Sits between the SSID producers/consumers and a simple dual-port BRAM (port A write, port B read).

Parameters:
ROW_BITS, 7, BRAM row address width (2^ROW_BITS rows)
COL_BITS, 5, column index width; row data width ROW_W = 2^COL_BITS
BRAM_LAT, 2, BRAM port-B read latency in cycles (>=1)
SSID_BITS = ROW_BITS+COL_BITS (derived, not overridable)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
clear_req  in  1  request full clear sweep (sampled in IDLE only)
wr_valid  in  1  mark request valid
wr_ssid  in  SSID_BITS  SSID to mark; row = [SSID_BITS-1:COL_BITS], col = [COL_BITS-1:0]
wr_ready  out  1  mark request accepted when wr_valid & wr_ready
rd_valid  in  1  query request valid
rd_ssid  in  SSID_BITS  SSID to query
rd_ready  out  1  query accepted when rd_valid & rd_ready
hit_valid  out  1  one-cycle pulse: query result valid
hit  out  1  queried bit value
busy  out  1  clear sweep or drain in progress
bram_we  out  1  port A write enable (registered)
bram_waddr  out  ROW_BITS  port A address (registered)
bram_wdata  out  ROW_W  port A data (registered)
bram_re  out  1  port B read enable
bram_raddr  out  ROW_BITS  port B address
bram_rdata  in  ROW_W  port B data, valid BRAM_LAT cycles after bram_re

Behaviour:
- Reset values: wr_ready=0, rd_ready=0, hit_valid=0, hit=0, bram_we=0, bram_re=0, bram_waddr=0, bram_wdata=0, busy=1. State goes to CLEAR with row counter 0. Last-grant flag = read, so the first contested grant goes to write.
- States: CLEAR, DRAIN, IDLE, ISSUE, WAIT, UPDATE.
- CLEAR: one registered write per cycle, bram_we=1, bram_wdata=0, rows 0..2^ROW_BITS-1 ascending. After the last row, go to DRAIN.
- DRAIN: bram_we=0 for BRAM_LAT+1 cycles, then IDLE with busy=0.
- IDLE: wr_ready/rd_ready are combinational.
  - Both low if clear_req=1. clear_req in IDLE enters CLEAR next cycle, busy=1.
  - Only one valid: that side's ready=1.
  - Both valid: round-robin. The side not granted last time wins; the loser's ready=0.
  - On accept at cycle T: latch op type, row, col; go to ISSUE.
- ISSUE (T+1): bram_re=1, bram_raddr=latched row. Go to WAIT if BRAM_LAT>1, else UPDATE.
- WAIT: BRAM_LAT-1 cycles; bram_re=0.
- UPDATE (T+1+BRAM_LAT): sample bram_rdata.
  - Query: at T+2+BRAM_LAT, hit_valid=1 for exactly one cycle, hit=rdata[col].
  - Mark: if rdata[col]=0, at T+2+BRAM_LAT bram_we=1, waddr=row, wdata=rdata | (1<<col). If the bit is already set, no write is issued.
  - Return to IDLE at T+2+BRAM_LAT; requests may be accepted in that cycle.
  - The next bram_re is therefore no earlier than the cycle after the write, so there is no read-after-write hazard and no bypass is needed.
- Ready is never high outside IDLE. Exactly one op is in flight. Throughput is one op per BRAM_LAT+2 cycles.
- Reset mid-operation aborts any op: no hit_valid or write from the aborted op, and the sweep restarts from row 0. Reset during CLEAR restarts at row 0.
- clear_req outside IDLE is ignored (not queued).
- Row counter wraps only at end of sweep; counters are sized so the 2^ROW_BITS-1 compare does not overflow.

Test Plan:
1. Deassert reset at cycle 0 (defaults) -> bram_we=1 for cycles 1..128, addrs 0..127, wdata=0; busy falls and readiness returns at cycle 132; no hit_valid throughout.
2. After clear, query ssid 0x0A5 (row 5, col 5) accepted at T -> bram_re at T+1 addr 5; hit_valid at T+4 with hit=0.
3. Mark 0x0A5, then query 0x0A5 -> write at T+4 addr 5 wdata 0x00000020; query returns hit=1. Query 0x0A4 -> hit=0.
4. Mark 0x0A5 again -> no bram_we pulse; op completes in 4 cycles.
5. wr_valid and rd_valid held high continuously -> grants alternate W,R,W,R; each grant is 4 cycles apart; never both readies high.
6. Assert reset during WAIT of a query -> no hit_valid; sweep restarts at row 0. clear_req pulse in IDLE after marking -> a later query of a marked SSID returns hit=0.
